// File: rtl/muldiv_hilo_ctrl_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: R-form funct codes,
// FSM state encoding, iteration count and small operand helpers.
package muldiv_hilo_ctrl_pkg;

    localparam int ITER_DEFAULT = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_div(input logic [5:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] f);
        return (f == F_MULT) || (f == F_DIV);
    endfunction

    // Two's-complement negate when en is set; -0x80000000 stays 0x80000000,
    // which is exactly its magnitude when read as unsigned.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_step.sv
// One iteration of the sequencer datapath: shift-add multiply step or
// restoring-divide step, chosen by i_div. Purely combinational.
module muldiv_step (
    input  logic        i_div,
    input  logic [63:0] i_acc,
    input  logic [63:0] i_mcand,
    input  logic [31:0] i_b,
    output logic [63:0] o_acc,
    output logic [63:0] o_mcand,
    output logic [31:0] o_b
);

    logic [32:0] w_rem_sh;
    logic [31:0] w_diff;
    logic        w_ge;

    // Divide keeps {remainder, quotient} in i_acc; the dividend bits shift out
    // of the quotient half into the remainder while quotient bits shift in.
    always_comb begin
        w_rem_sh = {i_acc[63:32], i_acc[31]};
        w_diff   = w_rem_sh[31:0] - i_b;
        w_ge     = (w_rem_sh >= {1'b0, i_b});
        if (i_div) begin
            o_acc   = {(w_ge ? w_diff : w_rem_sh[31:0]), i_acc[30:0], w_ge};
            o_mcand = i_mcand;
            o_b     = i_b;
        end else begin
            o_acc   = i_acc + (i_b[0] ? i_mcand : 64'd0);
            o_mcand = {i_mcand[62:0], 1'b0};
            o_b     = {1'b0, i_b[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers, with
// MTHI/MTLO service and ID stall. Optional MULDIV_EARLY_OUT_EN shortens multiply
// and divide-by-zero latency without changing results.
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Start,
    input  logic [5:0]  Funct,
    input  logic [31:0] Rdata1,
    input  logic [31:0] Rdata2,
    input  logic        RdReq,
    output logic        Busy,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    localparam int CW = $clog2(ITER);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [63:0]     r_acc;
    logic [63:0]     r_mcand;
    logic [31:0]     r_b;
    logic            r_div;
    logic            r_sign_a;
    logic            r_sign_b;
    logic            r_done;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;

    logic            w_busy;
    logic            w_signed;
    logic [31:0]     w_mag_a;
    logic [31:0]     w_mag_b;
    logic [63:0]     w_acc;
    logic [63:0]     w_mcand;
    logic [31:0]     w_b;
    logic            w_run_last;
    logic            w_skip_run;
    logic [63:0]     w_prod;
    logic [31:0]     w_quo;
    logic [31:0]     w_rem;
    logic [31:0]     w_rs;
    logic            w_div_zero;

    assign w_signed = is_signed_op(Funct);
    assign w_mag_a  = cond_neg32(Rdata1, w_signed & Rdata1[31]);
    assign w_mag_b  = cond_neg32(Rdata2, w_signed & Rdata2[31]);

    muldiv_step u_step (
        .i_div   (r_div),
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_b     (r_b),
        .o_acc   (w_acc),
        .o_mcand (w_mcand),
        .o_b     (w_b)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // w_b is the multiplier after this step's shift: nothing left to add.
    assign w_run_last = (r_cnt == '0) || (!r_div && (w_b == 32'd0));
    assign w_skip_run = is_div(Funct) && (Rdata2 == 32'd0);
`else
    assign w_run_last = (r_cnt == '0);
    assign w_skip_run = 1'b0;
`endif

    // Sign fix-up applied in FIX; the dividend is rebuilt from its magnitude
    // for the divide-by-zero HI value.
    assign w_prod     = (r_sign_a ^ r_sign_b) ? (~r_acc + 64'd1) : r_acc;
    assign w_quo      = cond_neg32(r_acc[31:0], r_sign_a ^ r_sign_b);
    assign w_rem      = cond_neg32(r_acc[63:32], r_sign_a);
    assign w_rs       = cond_neg32(r_mcand[31:0], r_sign_a);
    assign w_div_zero = (r_b == 32'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment up front covers every path, so no latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start && is_muldiv(Funct)) w_state_nxt = w_skip_run ? S_FIX : S_RUN;
            S_RUN:   if (w_run_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        Busy   = w_busy;
        Stall  = w_busy & (Start | RdReq);
        Done   = r_done;
        Hi     = r_hi;
        Lo     = r_lo;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_acc    <= 64'd0;
            r_mcand  <= 64'd0;
            r_b      <= 32'd0;
            r_div    <= 1'b0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= (r_state == S_FIX);
            case (r_state)
                S_IDLE: if (Start) begin
                    case (Funct)
                        F_MTHI: r_hi <= Rdata1;
                        F_MTLO: r_lo <= Rdata1;
                        F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                            r_div    <= is_div(Funct);
                            r_sign_a <= w_signed & Rdata1[31];
                            r_sign_b <= w_signed & Rdata2[31];
                            r_mcand  <= {32'd0, w_mag_a};
                            r_b      <= w_mag_b;
                            r_acc    <= is_div(Funct) ? {32'd0, w_mag_a} : 64'd0;
                            r_cnt    <= CW'(ITER - 1);
                        end
                        F_MFHI, F_MFLO: ;  // reads are served through RdReq
                        default: ;
                    endcase
                end
                S_RUN: begin
                    r_acc   <= w_acc;
                    r_mcand <= w_mcand;
                    r_b     <= w_b;
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: begin
                    if (r_div && w_div_zero) begin
                        r_hi <= w_rs;
                        r_lo <= 32'hFFFF_FFFF;
                    end else if (r_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
